traffic_injector: RTL and testbench

Simulation-side Hermes packet transmitter; the sending counterpart of the router-port traffic monitor.
- Accepts one message descriptor at a time over a req/ack handshake.
- Serialises it into Hermes flits on a router local/edge port using the rx/credit flit handshake: header, size, service, task_id, cons_id, then fill.
- Flit layout matches what the port monitors decode, so injected traffic is logged correctly end to end.

---
 rtl/traffic_injector_pkg.sv | 27 ++
 rtl/traffic_injector.sv | 181 ++++++++++++++++++
 tb/tb_traffic_injector.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/traffic_injector_pkg.sv
// Shared types and constants for the Hermes traffic injector.
// The service code below mirrors the TaskInjector package so injected
// traffic decodes identically in the port monitors.
package traffic_injector_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HEADER  = 2'd1,
      SIZE    = 2'd2,
      PAYLOAD = 2'd3
   } ti_state_e;

   // Flit index of each payload field, counted from the header (index 0).
   localparam logic [31:0] IDX_SERVICE = 32'd2;
   localparam logic [31:0] IDX_TASK    = 32'd3;
   localparam logic [31:0] IDX_CONS    = 32'd4;
   localparam logic [31:0] IDX_TS_LO   = 32'd5;
   localparam logic [31:0] IDX_TS_HI   = 32'd6;

   // Smallest size-flit value: service, task_id, cons_id (plus the two
   // timestamp words when timestamps are carried).
   localparam int unsigned MIN_SIZE_DEFAULT = 3;
   localparam int unsigned MIN_SIZE_TS      = 5;

   localparam logic [31:0] MESSAGE_DELIVERY = 32'h0000_0001;

endpackage

// File: rtl/traffic_injector.sv
// Hermes packet transmitter: takes one message descriptor over req/ack and
// serialises it as header, size, service, task_id, cons_id, then fill flits
// on a router port using the tx/credit handshake.
// Optional build macro: TRAFFIC_INJECTOR_TIMESTAMP_EN adds the acceptance
// tick as two flits after cons_id and raises the minimum size to 5.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | ack_o high, waiting for a descriptor
// HEADER  | presenting the zero-extended target address
// SIZE    | presenting the clamped size flit
// PAYLOAD | presenting service/task/cons/timestamp/fill by flit index
module traffic_injector
   import traffic_injector_pkg::*;
#(
   parameter int unsigned FLIT_SIZE = 32,
   parameter logic [31:0] FILL_BASE = 32'hCAFE_0000,
   parameter int unsigned MIN_SIZE  = MIN_SIZE_DEFAULT
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 req_i,
   output logic                 ack_o,
   input  logic [15:0]          target_i,
   input  logic [31:0]          service_i,
   input  logic [15:0]          task_id_i,
   input  logic [15:0]          cons_id_i,
   input  logic [31:0]          size_i,
   output logic                 tx_o,
   input  logic                 credit_i,
   output logic [FLIT_SIZE-1:0] data_o,
   input  logic [63:0]          tick_cntr_i,
   output logic                 busy_o,
   output logic [31:0]          pkt_cntr_o
);

`ifdef TRAFFIC_INJECTOR_TIMESTAMP_EN
   localparam logic [31:0] MIN_SIZE_EFF = 32'(MIN_SIZE_TS);
`else
   localparam logic [31:0] MIN_SIZE_EFF = 32'(MIN_SIZE);
`endif

   ti_state_e            state_q, state_d;
   logic [15:0]          target_q, target_d;
   logic [31:0]          service_q, service_d;
   logic [15:0]          task_q, task_d;
   logic [15:0]          cons_q, cons_d;
   logic [31:0]          size_q, size_d;
   logic [31:0]          rem_q, rem_d;
   logic [31:0]          idx_q, idx_d;
   logic [31:0]          pkt_q, pkt_d;
   logic [FLIT_SIZE-1:0] data_q, data_d;
   logic [31:0]          idx_nxt;
   logic [31:0]          payload_nxt;

`ifdef TRAFFIC_INJECTOR_TIMESTAMP_EN
   logic [63:0]          ts_q, ts_d;
`else
   logic                 unused_tick;
   assign unused_tick = ^tick_cntr_i;
`endif

   assign idx_nxt = idx_q + 32'd1;

   // Word for the next payload flit; service is loaded directly from SIZE.
   always_comb begin
      payload_nxt = FILL_BASE + idx_nxt;
      case (idx_nxt)
         IDX_TASK:  payload_nxt = {16'h0000, task_q};
         IDX_CONS:  payload_nxt = {16'h0000, cons_q};
`ifdef TRAFFIC_INJECTOR_TIMESTAMP_EN
         IDX_TS_LO: payload_nxt = ts_q[31:0];
         IDX_TS_HI: payload_nxt = ts_q[63:32];
`endif
         default:   ;
      endcase
   end

   // Next-state and datapath: data_q is loaded together with the state so
   // the flit is already valid in the cycle tx_o rises.
   always_comb begin
      state_d   = state_q;
      target_d  = target_q;
      service_d = service_q;
      task_d    = task_q;
      cons_d    = cons_q;
      size_d    = size_q;
      rem_d     = rem_q;
      idx_d     = idx_q;
      pkt_d     = pkt_q;
      data_d    = data_q;
`ifdef TRAFFIC_INJECTOR_TIMESTAMP_EN
      ts_d      = ts_q;
`endif
      case (state_q)
         IDLE: begin
            if (req_i) begin
               target_d  = target_i;
               service_d = service_i;
               task_d    = task_id_i;
               cons_d    = cons_id_i;
               size_d    = (size_i < MIN_SIZE_EFF) ? MIN_SIZE_EFF : size_i;
`ifdef TRAFFIC_INJECTOR_TIMESTAMP_EN
               ts_d      = tick_cntr_i;
`endif
               data_d    = {16'h0000, target_i};
               state_d   = HEADER;
            end
         end
         HEADER: begin
            if (credit_i) begin
               data_d  = size_q;
               state_d = SIZE;
            end
         end
         SIZE: begin
            if (credit_i) begin
               rem_d   = size_q;
               idx_d   = IDX_SERVICE;
               data_d  = service_q;
               state_d = PAYLOAD;
            end
         end
         PAYLOAD: begin
            if (credit_i) begin
               idx_d = idx_nxt;
               rem_d = rem_q - 32'd1;
               if (rem_q == 32'd1) begin
                  data_d  = '0;
                  pkt_d   = pkt_q + 32'd1;
                  state_d = IDLE;
               end else begin
                  data_d = payload_nxt;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset abandons any partial packet.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         target_q  <= '0;
         service_q <= '0;
         task_q    <= '0;
         cons_q    <= '0;
         size_q    <= '0;
         rem_q     <= '0;
         idx_q     <= '0;
         pkt_q     <= '0;
         data_q    <= '0;
`ifdef TRAFFIC_INJECTOR_TIMESTAMP_EN
         ts_q      <= '0;
`endif
      end else begin
         state_q   <= state_d;
         target_q  <= target_d;
         service_q <= service_d;
         task_q    <= task_d;
         cons_q    <= cons_d;
         size_q    <= size_d;
         rem_q     <= rem_d;
         idx_q     <= idx_d;
         pkt_q     <= pkt_d;
         data_q    <= data_d;
`ifdef TRAFFIC_INJECTOR_TIMESTAMP_EN
         ts_q      <= ts_d;
`endif
      end
   end

   // ack_o is held low while reset is asserted even though state reads IDLE.
   assign ack_o      = rst_ni && (state_q == IDLE);
   assign tx_o       = (state_q != IDLE);
   assign busy_o     = (state_q != IDLE);
   assign data_o     = data_q;
   assign pkt_cntr_o = pkt_q;

endmodule

// File: tb/tb_traffic_injector.sv
// Self-checking bench for traffic_injector: a table of directed packets,
// hand-written back-to-back and reset-abort sequences, then randomized
// packets with random credit, all checked against a flit-list model.
module tb_traffic_injector;
   import traffic_injector_pkg::*;

   localparam logic [31:0] FB = 32'hCAFE_0000;
`ifdef TRAFFIC_INJECTOR_TIMESTAMP_EN
   localparam int unsigned TB_MIN = 5;
`else
   localparam int unsigned TB_MIN = 3;
`endif

   logic        clk_i;
   logic        rst_ni;
   logic        req_i;
   logic        ack_o;
   logic [15:0] target_i;
   logic [31:0] service_i;
   logic [15:0] task_id_i;
   logic [15:0] cons_id_i;
   logic [31:0] size_i;
   logic        tx_o;
   logic        credit_i;
   logic [31:0] data_o;
   logic [63:0] tick_cntr_i;
   logic        busy_o;
   logic [31:0] pkt_cntr_o;

   traffic_injector #(.FLIT_SIZE(32), .FILL_BASE(FB), .MIN_SIZE(3)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .ack_o(ack_o),
      .target_i(target_i), .service_i(service_i), .task_id_i(task_id_i),
      .cons_id_i(cons_id_i), .size_i(size_i), .tx_o(tx_o), .credit_i(credit_i),
      .data_o(data_o), .tick_cntr_i(tick_cntr_i), .busy_o(busy_o),
      .pkt_cntr_o(pkt_cntr_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int exp_pkts = 0;

   typedef struct {
      logic [15:0] tg;
      logic [31:0] sv;
      logic [15:0] tk;
      logic [15:0] cs;
      logic [31:0] sz;
      logic [63:0] tick;
      int          mode;
      int          exp_xfer;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(negedge clk_i);
      cyc++;
   endtask

   // k-th flit of a packet, counted from the header.
   function automatic logic [31:0] model_word(input int unsigned k, input logic [15:0] tg,
         input logic [31:0] sv, input logic [15:0] tk, input logic [15:0] cs,
         input logic [31:0] sz_eff, input logic [63:0] tick);
      if (k == 0) return {16'h0, tg};
      if (k == 1) return sz_eff;
      if (k == 2) return sv;
      if (k == 3) return {16'h0, tk};
      if (k == 4) return {16'h0, cs};
`ifdef TRAFFIC_INJECTOR_TIMESTAMP_EN
      if (k == 5) return tick[31:0];
      if (k == 6) return tick[63:32];
`endif
      return FB + 32'(k);
   endfunction

   // mode 0: credit always 1; 1: random credit and junk descriptors while
   // busy; 2: credit low for 3 cycles while flit 3 is presented.
   // abort_k >= 0 pulses reset while flit abort_k is presented.
   task automatic send(input logic [15:0] tg, input logic [31:0] sv, input logic [15:0] tk,
         input logic [15:0] cs, input logic [31:0] sz, input logic [63:0] tick,
         input int mode, input int abort_k, output int n_xfer, output int hdr_cyc,
         output int last_cyc, output int stalls);
      logic [31:0] sz_eff;
      int unsigned k;
      int budget;
      logic c;
      sz_eff = (sz < TB_MIN) ? TB_MIN : sz;
      n_xfer = 0; stalls = 0; budget = 0; k = 0; last_cyc = 0;
      chk("ack_before_req", ack_o, 1'b1);
      req_i = 1'b1; target_i = tg; service_i = sv; task_id_i = tk; cons_id_i = cs;
      size_i = sz; tick_cntr_i = tick;
      step();
      req_i = 1'b0;
      tick_cntr_i = {$urandom, $urandom};
      hdr_cyc = cyc;
      while (k < sz_eff + 2 && budget < 1000) begin
         if (abort_k >= 0 && k == int'(abort_k)) begin
            rst_ni = 1'b0;
            #1;
            chk("abort_tx", tx_o, 1'b0);
            chk("abort_busy", busy_o, 1'b0);
            chk("abort_ack", ack_o, 1'b0);
            chk("abort_pkt_cntr", pkt_cntr_o, 32'd0);
            exp_pkts = 0;
            step();
            rst_ni = 1'b1;
            return;
         end
         chk("flit_tx", tx_o, 1'b1);
         chk("flit_busy", busy_o, 1'b1);
         chk("flit_ack", ack_o, 1'b0);
         chk($sformatf("flit_data_k%0d", k), data_o, model_word(k, tg, sv, tk, cs, sz_eff, tick));
         case (mode)
            1: c = ($urandom_range(0, 2) != 0);
            2: c = !(k == 3 && stalls < 3);
            default: c = 1'b1;
         endcase
         if (mode == 1) begin
            req_i = 1'($urandom_range(0, 1));
            target_i = 16'($urandom); service_i = $urandom; size_i = $urandom_range(0, 9);
         end
         credit_i = c;
         if (c) begin
            k++; n_xfer++; last_cyc = cyc;
         end else begin
            stalls++;
         end
         step();
         budget++;
      end
      if (budget >= 1000) chk("timeout", 1'b1, 1'b0);
      req_i = 1'b0;
      credit_i = 1'b1;
      exp_pkts++;
      chk("end_tx", tx_o, 1'b0);
      chk("end_busy", busy_o, 1'b0);
      chk("end_pkt_cntr", pkt_cntr_o, 32'(exp_pkts));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      vec_t tbl[7];
      int n, h, l, s, hb, lb, sb, nb;
      tbl[0] = '{16'h0102, MESSAGE_DELIVERY, 16'd7, 16'd9, 32'd5, 64'd0, 0, 7};
      tbl[1] = '{16'h0033, 32'h10, 16'd1, 16'd2, 32'd0, 64'd0, 0, TB_MIN + 2};
      tbl[2] = '{16'hFFFF, 32'hDEAD_BEEF, 16'hFFFF, 16'h8000, 32'd3, 64'd0, 0, TB_MIN + 2};
      tbl[3] = '{16'h0A0B, 32'h22, 16'd7, 16'd9, 32'd5, 64'd0, 2, 7};
      tbl[4] = '{16'h1111, 32'h33, 16'd4, 16'd5, 32'd10, 64'hFFFF_FFFF_0000_0001, 0, 12};
      tbl[5] = '{16'h0201, 32'h44, 16'd3, 16'd3, 32'd6, 64'h1_0000_0002, 0, 8};
      tbl[6] = '{16'h0000, 32'h0, 16'd0, 16'd0, 32'd1, 64'd0, 0, TB_MIN + 2};

      rst_ni = 1'b0; req_i = 1'b0; credit_i = 1'b1;
      target_i = '0; service_i = '0; task_id_i = '0; cons_id_i = '0; size_i = '0;
      tick_cntr_i = '0;
      step(); step();
      chk("rst_ack", ack_o, 1'b0);
      chk("rst_tx", tx_o, 1'b0);
      chk("rst_data", data_o, 32'd0);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_pkt_cntr", pkt_cntr_o, 32'd0);
      rst_ni = 1'b1;
      #1;
      chk("idle_ack", ack_o, 1'b1);
      step();

      for (int i = 0; i < 7; i++) begin
         send(tbl[i].tg, tbl[i].sv, tbl[i].tk, tbl[i].cs, tbl[i].sz, tbl[i].tick,
              tbl[i].mode, -1, n, h, l, s);
         chk($sformatf("vec%0d_xfers", i), 32'(n), 32'(tbl[i].exp_xfer));
         if (tbl[i].mode == 2) begin
            chk($sformatf("vec%0d_stalls", i), 32'(s), 32'd3);
            chk($sformatf("vec%0d_span", i), 32'(l - h), 32'(tbl[i].exp_xfer - 1 + 3));
         end else begin
            chk($sformatf("vec%0d_span", i), 32'(l - h), 32'(tbl[i].exp_xfer - 1));
         end
         step();
      end

      // Back-to-back descriptors: one IDLE cycle between packets.
      send(16'h0505, 32'h55, 16'd1, 16'd2, 32'd4, 64'd0, 0, -1, n, h, l, s);
      send(16'h0606, 32'h66, 16'd3, 16'd4, 32'd3, 64'd0, 0, -1, nb, hb, lb, sb);
      chk("b2b_gap", 32'(hb - l), 32'd2);
      chk("b2b_xfers", 32'(nb), 32'(TB_MIN + 2));
      step();

      // Reset while flit 4 (cons_id) is presented, then a clean packet.
      send(16'h0707, 32'h77, 16'd5, 16'd6, 32'd6, 64'd0, 0, 4, n, h, l, s);
      chk("abort_xfers", 32'(n), 32'd4);
      step();
      send(16'h0808, 32'h88, 16'd7, 16'd8, 32'd5, 64'd0, 0, -1, n, h, l, s);
      chk("post_abort_xfers", 32'(n), 32'd7);
      step();

      for (int i = 0; i < 40; i++) begin
         logic [31:0] rsz;
         rsz = $urandom_range(0, 12);
         send(16'($urandom), $urandom, 16'($urandom), 16'($urandom), rsz,
              {$urandom, $urandom}, 1, -1, n, h, l, s);
         chk("rnd_xfers", 32'(n), ((rsz < TB_MIN) ? 32'(TB_MIN) : rsz) + 32'd2);
         chk("rnd_span", 32'(l - h), 32'(n - 1 + s));
         if ($urandom_range(0, 1) == 1) step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
